rf_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the integer register file in the pipelined core. It shares the single register-file write port between the in-order pipeline writeback stage (P) and the multi-cycle MUL/DIV unit (M). Arbitration is starvation-bounded, and the write is registered one stage before the register file. It also tracks destination registers with an outstanding M operation and reports read-after-write hazards to the hazard unit.

---
 rtl/rf_wb_arbiter_pkg.sv | 46 ++++
 rtl/rf_wb_arbiter_checker.sv | 34 +++
 rtl/rf_wb_arbiter_scoreboard.sv | 72 +++++++
 rtl/rf_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, grant encoding and starvation-counter helper for the
// register-file writeback arbiter.
`ifndef XLEN
`define XLEN 64
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef RF_WB_MAX_WAIT
`define RF_WB_MAX_WAIT 4
`endif

package rf_wb_arbiter_pkg;

  localparam int unsigned RF_XLEN     = `XLEN;
  localparam int unsigned RF_AW       = `REG_ADDR_WIDTH;
  localparam int unsigned RF_MAX_WAIT = `RF_WB_MAX_WAIT;
  localparam int unsigned CNT_W       = 4;

  typedef logic [CNT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_P    = 2'd1,
    GRANT_M    = 2'd2
  } grant_e;

  // M's denial counter: cleared when M is idle or served, saturates at limit.
  function automatic wait_cnt_t wait_cnt_next(
    input logic      m_valid,
    input logic      m_hs,
    input wait_cnt_t cnt,
    input wait_cnt_t limit
  );
    wait_cnt_t nxt;
    if (!m_valid || m_hs) begin
      nxt = 4'd0;
    end else if (cnt >= limit) begin
      nxt = limit;
    end else begin
      nxt = cnt + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_checker.sv
// Invariants of the writeback arbiter, kept apart from the datapath.
module rf_wb_arbiter_checker
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned MAX_WAIT = RF_MAX_WAIT
) (
  input logic          clk,
  input logic          rst_n,
  input logic          p_hs,
  input logic          m_hs,
  input logic          m_valid,
  input logic          m_ready,
  input logic          starve,
  input wait_cnt_t     wait_cnt,
  input logic          wr_en,
  input logic [AW-1:0] wr_addr
);

  localparam wait_cnt_t MAX_C = wait_cnt_t'(MAX_WAIT);

  a_one_handshake: assert property (@(posedge clk) disable iff (!rst_n)
    !(p_hs && m_hs));

  a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    wait_cnt <= MAX_C);

  a_starve_wins: assert property (@(posedge clk) disable iff (!rst_n)
    (starve && m_valid) |-> m_ready);

  a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |-> (wr_addr != {AW{1'b0}}));

endmodule

// File: rtl/rf_wb_arbiter_scoreboard.sv
// rf_scoreboard: per-register pending bits for outstanding MUL/DIV results,
// plus the two decode-stage busy lookups including the in-flight write.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  localparam int unsigned NUM_REGS = 1 << AW;

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pending_nxt_s;
  logic                rs1_busy_s;
  logic                rs2_busy_s;

  // Next pending vector: clear first so a same-cycle set on that register wins.
  always_comb begin
    pending_nxt_s = pending_r;
    if (clr_en) begin
      pending_nxt_s[clr_addr] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (set_en && (set_addr != {AW{1'b0}})) begin
      pending_nxt_s[set_addr] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Busy lookups; the write-stage term covers the cycle before the file commits.
  always_comb begin
    rs1_busy_s = 1'b0;
    rs2_busy_s = 1'b0;
    if (rs1_addr != {AW{1'b0}}) begin
      rs1_busy_s = pending_r[rs1_addr] || (wr_en && (wr_addr == rs1_addr));
    end else begin
      rs1_busy_s = 1'b0;
    end
    if (rs2_addr != {AW{1'b0}}) begin
      rs2_busy_s = pending_r[rs2_addr] || (wr_en && (wr_addr == rs2_addr));
    end else begin
      rs2_busy_s = 1'b0;
    end
  end

  assign rs1_busy = rs1_busy_s;
  assign rs2_busy = rs2_busy_s;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback (P) and the
// MUL/DIV unit (M) with bounded starvation; registers the write one stage early.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = RF_MAX_WAIT,
  parameter int unsigned XLEN     = RF_XLEN,
  parameter int unsigned AW       = RF_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p_valid,
  output logic            p_ready,
  input  logic [AW-1:0]   p_addr,
  input  logic [XLEN-1:0] p_data,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [AW-1:0]   m_addr,
  input  logic [XLEN-1:0] m_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data
);

  localparam wait_cnt_t MAX_C = wait_cnt_t'(MAX_WAIT);

  wait_cnt_t       wait_cnt_r;
  logic            starve_s;
  logic            p_ready_s;
  logic            m_ready_s;
  logic            p_hs_s;
  logic            m_hs_s;
  grant_e          grant_s;
  logic            wr_en_r;
  logic [AW-1:0]   wr_addr_r;
  logic [XLEN-1:0] wr_data_r;

  // Grant: P has priority until M has been denied MAX_WAIT cycles in a row.
  // Only valids and registered state feed ready, never addresses or data.
  always_comb begin
    starve_s  = (wait_cnt_r == MAX_C);
    m_ready_s = m_valid && (!p_valid || starve_s);
    p_ready_s = !(m_valid && starve_s);
    p_hs_s    = p_valid && p_ready_s;
    m_hs_s    = m_valid && m_ready_s;
    if (m_hs_s) begin
      grant_s = GRANT_M;
    end else if (p_hs_s) begin
      grant_s = GRANT_P;
    end else begin
      grant_s = GRANT_NONE;
    end
  end

  // Starvation counter and registered write stage; x0 handshakes never write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 4'd0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {AW{1'b0}};
      wr_data_r  <= {XLEN{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_next(m_valid, m_hs_s, wait_cnt_r, MAX_C);
      case (grant_s)
        GRANT_M: begin
          wr_en_r <= (m_addr != {AW{1'b0}});
          if (m_addr != {AW{1'b0}}) begin
            wr_addr_r <= m_addr;
            wr_data_r <= m_data;
          end
        end
        GRANT_P: begin
          wr_en_r <= (p_addr != {AW{1'b0}});
          if (p_addr != {AW{1'b0}}) begin
            wr_addr_r <= p_addr;
            wr_data_r <= p_data;
          end
        end
        default: begin
          wr_en_r <= 1'b0;
        end
      endcase
    end
  end

  rf_scoreboard #(
    .AW (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (iss_valid),
    .set_addr (iss_addr),
    .clr_en   (m_hs_s),
    .clr_addr (m_addr),
    .wr_en    (wr_en_r),
    .wr_addr  (wr_addr_r),
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .rs1_busy (rs1_busy_o),
    .rs2_busy (rs2_busy_o)
  );

  rf_wb_arbiter_checker #(
    .AW       (AW),
    .MAX_WAIT (MAX_WAIT)
  ) u_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .p_hs     (p_hs_s),
    .m_hs     (m_hs_s),
    .m_valid  (m_valid),
    .m_ready  (m_ready_s),
    .starve   (starve_s),
    .wait_cnt (wait_cnt_r),
    .wr_en    (wr_en_r),
    .wr_addr  (wr_addr_r)
  );

  assign p_ready = p_ready_s;
  assign m_ready = m_ready_s;
  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: writeback, starvation pattern, scoreboard
// hazards, x0 handling and asynchronous reset.
module tb_rf_wb_arbiter;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            p_valid;
  logic            p_ready;
  logic [AW-1:0]   p_addr;
  logic [XLEN-1:0] p_data;
  logic            m_valid;
  logic            m_ready;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_addr;
  logic [AW-1:0]   rs1_addr_i;
  logic [AW-1:0]   rs2_addr_i;
  logic            rs1_busy_o;
  logic            rs2_busy_o;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  int n_checks;
  int n_pass;

  rf_wb_arbiter #(
    .MAX_WAIT (4),
    .XLEN     (XLEN),
    .AW       (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p_valid    (p_valid),
    .p_ready    (p_ready),
    .p_addr     (p_addr),
    .p_data     (p_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_addr     (m_addr),
    .m_data     (m_data),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_busy_o (rs1_busy_o),
    .rs2_busy_o (rs2_busy_o),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_valid   = 1'b0;
    m_valid   = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    p_addr     = 5'd0;
    p_data     = 64'd0;
    m_addr     = 5'd0;
    m_data     = 64'd0;
    iss_addr   = 5'd0;
    rs1_addr_i = 5'd0;
    rs2_addr_i = 5'd0;
    idle();
    #12;
    check("rst_wr_en", wr_en, 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    check("rst_p_ready", p_ready, 64'd1);
    check("rst_m_ready", m_ready, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // P only, three back-to-back writes to x5
    p_valid = 1'b1; p_addr = 5'd5; p_data = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      #1 check("p_only_ready", p_ready, 64'd1);
      cyc();
      check("p_only_wr_en", wr_en, 64'd1);
      check("p_only_wr_addr", 64'(wr_addr), 64'd5);
      check("p_only_wr_data", wr_data, 64'h1234);
    end
    idle();
    cyc();
    check("idle_wr_en", wr_en, 64'd0);
    check("idle_wr_addr_hold", 64'(wr_addr), 64'd5);

    // P and M both continuously valid: M wins every 5th cycle
    p_valid = 1'b1; p_addr = 5'd3; p_data = 64'h33;
    m_valid = 1'b1; m_addr = 5'd4; m_data = 64'h44;
    for (int c = 1; c <= 10; c++) begin
      #1;
      check("starve_m_ready", m_ready, (c % 5 == 0) ? 64'd1 : 64'd0);
      check("starve_p_ready", p_ready, (c % 5 == 0) ? 64'd0 : 64'd1);
      cyc();
      check("starve_wr_addr", 64'(wr_addr), (c % 5 == 0) ? 64'd4 : 64'd3);
      check("starve_wr_data", wr_data, (c % 5 == 0) ? 64'h44 : 64'h33);
    end
    idle();
    cyc();

    // Issue to x7, hazard until the M result is written
    rs1_addr_i = 5'd7; rs2_addr_i = 5'd8;
    iss_valid = 1'b1; iss_addr = 5'd7;
    #1 check("iss_cycle_busy", rs1_busy_o, 64'd0);
    cyc();
    iss_valid = 1'b0;
    check("pend_busy1", rs1_busy_o, 64'd1);
    check("pend_rs2_free", rs2_busy_o, 64'd0);
    cyc();
    check("pend_busy2", rs1_busy_o, 64'd1);
    m_valid = 1'b1; m_addr = 5'd7; m_data = 64'hABCD;
    #1 check("m_alone_ready", m_ready, 64'd1);
    check("m_hs_busy", rs1_busy_o, 64'd1);
    cyc();
    m_valid = 1'b0;
    check("m_wr_en", wr_en, 64'd1);
    check("m_wr_addr", 64'(wr_addr), 64'd7);
    check("m_wr_data", wr_data, 64'hABCD);
    check("wr_cycle_busy", rs1_busy_o, 64'd1);
    cyc();
    check("after_wr_busy", rs1_busy_o, 64'd0);

    // Same-cycle issue and M handshake on x9: set wins
    rs1_addr_i = 5'd9;
    iss_valid = 1'b1; iss_addr = 5'd9;
    m_valid = 1'b1; m_addr = 5'd9; m_data = 64'h99;
    cyc();
    idle();
    check("x9_wr_en", wr_en, 64'd1);
    cyc();
    check("x9_still_pending", rs1_busy_o, 64'd1);

    // P write to x0: accepted, no register-file write, x0 never busy
    rs1_addr_i = 5'd0; rs2_addr_i = 5'd9;
    p_valid = 1'b1; p_addr = 5'd0; p_data = 64'hFFFF;
    #1 check("x0_p_ready", p_ready, 64'd1);
    check("x0_rs1_busy", rs1_busy_o, 64'd0);
    cyc();
    idle();
    check("x0_wr_en", wr_en, 64'd0);
    check("x0_rs1_busy_after", rs1_busy_o, 64'd0);
    check("x9_rs2_busy", rs2_busy_o, 64'd1);

    // Asynchronous reset mid-stream with wr_en high and x9 pending
    rs1_addr_i = 5'd12;
    p_valid = 1'b1; p_addr = 5'd12; p_data = 64'h55;
    cyc();
    check("pre_rst_wr_en", wr_en, 64'd1);
    check("pre_rst_rs1_busy", rs1_busy_o, 64'd1);
    #2 rst_n = 1'b0;
    idle();
    #1;
    check("async_wr_en", wr_en, 64'd0);
    check("async_wr_addr", 64'(wr_addr), 64'd0);
    check("async_wr_data", wr_data, 64'd0);
    check("async_rs1_busy", rs1_busy_o, 64'd0);
    check("async_rs2_busy", rs2_busy_o, 64'd0);
    check("async_m_ready", m_ready, 64'd0);
    cyc();
    rst_n = 1'b1;
    p_valid = 1'b1; p_addr = 5'd3; p_data = 64'h7;
    cyc();
    idle();
    check("post_rst_wr_en", wr_en, 64'd1);
    check("post_rst_wr_addr", 64'(wr_addr), 64'd3);
    check("post_rst_rs2_free", rs2_busy_o, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
